// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the bit-period constant used to size the command assembler's
// inter-byte timeout, and the assembler's state encoding.
package uart_pkg;

    // System clocks per UART bit period (50 MHz / 19200 baud).
    localparam int unsigned BAUD = 2604;

    // Inter-byte gap allowed between high and low byte, in bit periods.
    localparam int unsigned TIMEOUT_BAUDS = 20;

    localparam int unsigned TIMEOUT_DEFAULT = TIMEOUT_BAUDS * BAUD;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_LO = 1'b1
    } asm_state_e;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Handshake bundle between the UART receiver / command consumer and the
// command assembler.
//   rx_rdy      receiver byte-available flag (held until cleared)
//   rx_data     received byte, valid while rx_rdy is high
//   clr_rx_rdy  one-cycle acknowledge back to the receiver
//   clr_cmd_rdy consumer acknowledge of the assembled command
//   cmd         assembled command {high byte, low byte}
//   cmd_rdy     assembled command valid
//   frame_err   one-cycle pulse on inter-byte timeout
// master: receiver/consumer side.  slave: assembler side.
interface uart_cmd_assembler_if;

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frame_err;

    modport master (
        output rx_rdy,
        output rx_data,
        output clr_cmd_rdy,
        input  clr_rx_rdy,
        input  cmd,
        input  cmd_rdy,
        input  frame_err
    );

    modport slave (
        input  rx_rdy,
        input  rx_data,
        input  clr_cmd_rdy,
        output clr_rx_rdy,
        output cmd,
        output cmd_rdy,
        output frame_err
    );

endinterface

// File: rtl/uart_cmd_assembler.sv
// Assembles two consecutive UART bytes into a 16-bit command
// {high byte, low byte}. If the low byte does not arrive within TIMEOUT
// clocks of the high byte, the partial command is dropped and frame_err
// pulses for one cycle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    handshake bundle (slave side), see uart_cmd_assembler_if
//
// Parameter TIMEOUT must lie in 1..65536 (16-bit gap counter).
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | waiting for the high byte; gap counter held at 0
// ST_WAIT_LO  | high byte captured; counting the gap to the low byte
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_assembler_if.slave  bus
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    asm_state_e  state_q,     state_d;
    logic [7:0]  byte_hi_q,   byte_hi_d;
    logic [15:0] cmd_q,       cmd_d;
    logic        cmd_rdy_q,   cmd_rdy_d;
    logic [15:0] cnt_q,       cnt_d;
    logic        frame_err_q, frame_err_d;
    logic        clr_rx_rdy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_hi_q   <= 8'h00;
            cmd_q       <= 16'h0000;
            cmd_rdy_q   <= 1'b0;
            cnt_q       <= 16'h0000;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_hi_q   <= byte_hi_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_hi_d    = byte_hi_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        cnt_d        = cnt_q;
        frame_err_d  = 1'b0;
        clr_rx_rdy_c = 1'b0;

        // Consumer acknowledge first so that a completing command below
        // overrides it in the same cycle.
        if (bus.clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'h0000;
                if (bus.rx_rdy) begin
                    clr_rx_rdy_c = 1'b1;
                    byte_hi_d    = bus.rx_data;
                    cmd_rdy_d    = 1'b0;
                    state_d      = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                // A byte arriving on the last allowed cycle is still taken.
                if (bus.rx_rdy) begin
                    clr_rx_rdy_c = 1'b1;
                    cmd_d        = {byte_hi_q, bus.rx_data};
                    cmd_rdy_d    = 1'b1;
                    cnt_d        = 16'h0000;
                    state_d      = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    frame_err_d = 1'b1;
                    byte_hi_d   = 8'h00;
                    cnt_d       = 16'h0000;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Acknowledge is decoded combinationally so the receiver's flag drops
    // on the same edge that consumes the byte; it is masked while reset is
    // held so nothing is acknowledged during reset.
    assign bus.clr_rx_rdy = clr_rx_rdy_c & rst_n;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
module tb_uart_cmd_assembler;
    import uart_pkg::*;

    localparam int T = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int clr_cnt = 0;
    int fe_cnt  = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_cmd;
    logic [15:0] last_cmd = 16'h0000;

    uart_cmd_assembler_if bus();

    uart_cmd_assembler #(.TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Count acknowledge and frame-error cycles, sampled mid low phase.
    always begin
        @(negedge clk);
        #2;
        if (bus.clr_rx_rdy === 1'b1) clr_cnt <= clr_cnt + 1;
        if (bus.frame_err === 1'b1)  fe_cnt  <= fe_cnt + 1;
    end

    // Receiver model: raises rx_rdy and holds it until acknowledged.
    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        bit got = 1'b0;
        @(negedge clk);
        bus.rx_data     = b;
        bus.rx_rdy      = 1'b1;
        bus.clr_cmd_rdy = with_clr;
        #1;
        for (int i = 0; i < 8 && !got; i++) begin
            if (bus.clr_rx_rdy === 1'b1) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        bus.rx_rdy      = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout byte=%02h: no clr_rx_rdy seen, required one", b);
        end
    endtask

    task automatic test_reset();
        bus.rx_rdy      = 1'b1;
        bus.rx_data     = 8'h99;
        bus.clr_cmd_rdy = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL rst_clr_rx_rdy got=%b exp=0", bus.clr_rx_rdy); end
        checks++; if (bus.cmd !== 16'h0000)    begin errors++; $display("FAIL rst_cmd got=%h exp=0000", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b0)    begin errors++; $display("FAIL rst_cmd_rdy got=%b exp=0", bus.cmd_rdy); end
        checks++; if (bus.frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err got=%b exp=0", bus.frame_err); end
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int c0;
        #5;
        c0 = clr_cnt;
        send_byte(8'hA5, 1'b0);
        exp_q.push_back(16'hA53C);
        send_byte(8'h3C, 1'b0);
        @(negedge clk);
        exp_cmd = exp_q.pop_front();
        last_cmd = exp_cmd;
        checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL basic_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_cmd_rdy_latency got=%b exp=1", bus.cmd_rdy); end
        repeat (2) @(negedge clk);
        #5;
        checks++; if (clr_cnt - c0 != 2) begin errors++; $display("FAIL basic_clr_pulses got=%0d exp=2", clr_cnt - c0); end
    endtask

    task automatic test_timeout();
        int hit = -1;
        int n   = 0;
        send_byte(8'h12, 1'b0);
        for (int k = 0; k < T + 4; k++) begin
            @(negedge clk);
            if (k == 3) bus.clr_cmd_rdy = 1'b1;
            if (k == 4) bus.clr_cmd_rdy = 1'b0;
            #1;
            if (bus.frame_err === 1'b1) begin
                n++;
                if (hit < 0) hit = k;
            end
        end
        checks++; if (hit != T)              begin errors++; $display("FAIL timeout_cycle got=%0d exp=%0d", hit, T); end
        checks++; if (n != 1)                begin errors++; $display("FAIL timeout_pulse_len got=%0d exp=1", n); end
        checks++; if (bus.cmd !== last_cmd)  begin errors++; $display("FAIL timeout_cmd_held got=%h exp=%h", bus.cmd, last_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b0)  begin errors++; $display("FAIL timeout_cmd_rdy got=%b exp=0", bus.cmd_rdy); end
        send_byte(8'hC3, 1'b0);
        exp_q.push_back(16'hC35A);
        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        exp_cmd = exp_q.pop_front();
        last_cmd = exp_cmd;
        checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL after_timeout_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL after_timeout_cmd_rdy got=%b exp=1", bus.cmd_rdy); end
    endtask

    task automatic test_boundary();
        int f0;
        #5;
        f0 = fe_cnt;
        send_byte(8'h66, 1'b0);
        repeat (T - 1) @(negedge clk);
        exp_q.push_back(16'h6699);
        send_byte(8'h99, 1'b0);
        @(negedge clk);
        exp_cmd = exp_q.pop_front();
        last_cmd = exp_cmd;
        checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL boundary_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL boundary_cmd_rdy got=%b exp=1", bus.cmd_rdy); end
        repeat (T + 4) @(negedge clk);
        #5;
        checks++; if (fe_cnt != f0) begin errors++; $display("FAIL boundary_frame_err got=%0d exp=0 pulses", fe_cnt - f0); end
    endtask

    task automatic test_set_wins();
        send_byte(8'hBE, 1'b0);
        exp_q.push_back(16'hBEEF);
        send_byte(8'hEF, 1'b1);
        @(negedge clk);
        exp_cmd = exp_q.pop_front();
        last_cmd = exp_cmd;
        checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL set_wins_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL set_wins_cmd_rdy got=%b exp=1", bus.cmd_rdy); end
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        #1;
        checks++; if (bus.cmd_rdy !== 1'b0)  begin errors++; $display("FAIL ack_clears got=%b exp=0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== last_cmd) begin errors++; $display("FAIL ack_cmd_held got=%h exp=%h", bus.cmd, last_cmd); end
    endtask

    task automatic test_overwrite();
        logic [7:0] pairs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int p = 0; p < 4; p += 2) begin
            send_byte(pairs[p], 1'b0);
            exp_q.push_back({pairs[p], pairs[p + 1]});
            send_byte(pairs[p + 1], 1'b0);
            @(negedge clk);
            exp_cmd = exp_q.pop_front();
            last_cmd = exp_cmd;
            checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL overwrite_cmd%0d got=%h exp=%h", p / 2, bus.cmd, exp_cmd); end
            checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL overwrite_cmd_rdy%0d got=%b exp=1", p / 2, bus.cmd_rdy); end
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        send_byte(8'h55, 1'b0);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.rx_data = 8'hEE;
        bus.rx_rdy  = 1'b1;
        #1;
        checks++; if (bus.clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL midrst_clr_rx_rdy got=%b exp=0", bus.clr_rx_rdy); end
        checks++; if (bus.cmd !== 16'h0000)    begin errors++; $display("FAIL midrst_cmd got=%h exp=0000", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b0)    begin errors++; $display("FAIL midrst_cmd_rdy got=%b exp=0", bus.cmd_rdy); end
        checks++; if (bus.frame_err !== 1'b0)  begin errors++; $display("FAIL midrst_frame_err got=%b exp=0", bus.frame_err); end
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        rst_n      = 1'b1;
        last_cmd   = 16'h0000;
        #5;
        f0 = fe_cnt;
        repeat (T + 4) @(negedge clk);
        #5;
        checks++; if (fe_cnt != f0) begin errors++; $display("FAIL midrst_no_frame_err got=%0d exp=0 pulses", fe_cnt - f0); end
        send_byte(8'h01, 1'b0);
        exp_q.push_back(16'h0102);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        exp_cmd = exp_q.pop_front();
        last_cmd = exp_cmd;
        checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL midrst_next_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL midrst_next_cmd_rdy got=%b exp=1", bus.cmd_rdy); end
    endtask

    // Stub receiver that never clears rx_rdy: the same byte is taken twice.
    task automatic test_stub_hold();
        int c0;
        repeat (2) @(negedge clk);
        #5;
        c0 = clr_cnt;
        @(negedge clk);
        bus.rx_data = 8'h77;
        bus.rx_rdy  = 1'b1;
        exp_q.push_back(16'h7777);
        repeat (2) @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        exp_cmd = exp_q.pop_front();
        last_cmd = exp_cmd;
        checks++; if (bus.cmd !== exp_cmd)  begin errors++; $display("FAIL stub_cmd got=%h exp=%h", bus.cmd, exp_cmd); end
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL stub_cmd_rdy got=%b exp=1", bus.cmd_rdy); end
        #5;
        checks++; if (clr_cnt - c0 != 2) begin errors++; $display("FAIL stub_double_capture got=%0d exp=2", clr_cnt - c0); end
    endtask

    initial begin
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_boundary();
        test_set_wins();
        test_overwrite();
        test_reset_mid();
        test_stub_hold();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_assembler.md
UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 Parameter: TIMEOUT, 52080, clk cycles allowed between high and low byte (20 baud periods at 2604 clks/bit).
REQ-002 clk  input  1  50MHz system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_rdy  input  1  byte-available flag from the UART receiver; held high until cleared.
REQ-005 rx_data  input  8  received byte; valid while rx_rdy high.
REQ-006 clr_rx_rdy  output  1  one-cycle pulse acknowledging the byte to the receiver.
REQ-007 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-008 cmd  output  16  assembled command, {high byte, low byte}.
REQ-009 cmd_rdy  output  1  assembled command valid.
REQ-010 frame_err  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-011 States SHALL be IDLE (awaiting high byte) and WAIT_LO (awaiting low byte); encoding is a 1-bit enum.
REQ-012 IDLE with rx_rdy=1 SHALL: pulse clr_rx_rdy that cycle, load rx_data into internal byte_hi, clear cmd_rdy, clear timeout counter, go WAIT_LO.
REQ-013 WAIT_LO with rx_rdy=1 SHALL: pulse clr_rx_rdy that cycle, load cmd <= {byte_hi, rx_data}, set cmd_rdy, go IDLE.
REQ-014 clr_rx_rdy SHALL be a combinational decode of state and rx_rdy, so the receiver's flag clears on the same edge as the state transition and no byte is consumed twice.
REQ-015 cmd_rdy SHALL be visible the cycle after the low byte's rx_rdy is sampled (latency 1 clk).
REQ-016 cmd SHALL hold its value from capture until the next completed command; it SHALL NOT change on a high-byte capture or timeout.
REQ-017 clr_cmd_rdy SHALL clear cmd_rdy on the next edge; a simultaneous set (REQ-013) SHALL win over clr_cmd_rdy.
REQ-018 Timeout counter: 16-bit, increments each cycle in WAIT_LO, held at 0 in IDLE.
REQ-019 When the counter equals TIMEOUT-1 in WAIT_LO and rx_rdy=0, the block SHALL pulse frame_err for exactly one cycle, discard byte_hi, and go IDLE.
REQ-020 If rx_rdy=1 on the same cycle the counter reaches TIMEOUT-1, the byte SHALL be accepted per REQ-013 and frame_err SHALL stay 0.
REQ-021 A completed command overwrites an unacknowledged cmd; no overrun flag is kept.
REQ-022 clr_cmd_rdy in WAIT_LO SHALL only affect cmd_rdy, never state or counter.

Reset
REQ-023 On rst_n low: state=IDLE, byte_hi=0x00, cmd=0x0000, cmd_rdy=0, timeout counter=0, frame_err=0, clr_rx_rdy=0 (no rx_rdy acknowledged during reset).
REQ-024 Reset asserted mid-command (WAIT_LO) SHALL drop the partial command; no frame_err is generated for it.

Structure
REQ-025 Shared package uart_pkg SHALL hold the BAUD constant (2604) and the assembler state enum; TIMEOUT default is derived from BAUD.
REQ-026 Single module, no sub-modules; the existing UART receiver is instantiated beside it at the wrapper level, not inside it.

Verification
REQ-027 Bytes 0xA5 then 0x3C via receiver model -> cmd=0xA53C, cmd_rdy=1 one clk after second rx_rdy; clr_rx_rdy pulsed exactly twice, one cycle each.
REQ-028 High byte 0x12, no low byte -> frame_err one-cycle pulse TIMEOUT clks after capture, state IDLE, cmd and cmd_rdy unchanged.
REQ-029 Low byte rx_rdy on exactly the timeout cycle (TIMEOUT=16 override) -> cmd accepted, frame_err never asserted.
REQ-030 cmd_rdy=1 with clr_cmd_rdy asserted on the completion cycle of next command 0xBEEF -> cmd_rdy stays 1, cmd=0xBEEF.
REQ-031 rst_n pulsed low while in WAIT_LO after byte 0x55 -> all outputs reset; next bytes 0x01,0x02 yield cmd=0x0102.
REQ-032 rx_rdy held high without receiver clearing (stub) -> bench detects two consecutive captures; with real receiver, exactly one capture per byte.
